decode_issue_stage: RTL and testbench
=====================================

# decode_issue_stage

Decode-and-issue stage directly upstream of the 3-bit-opcode ALU. It accepts RV32I OP and OP-IMM instructions, reads operands from an internal 32x32 register file, and maps each instruction to the ALU opcode. It issues `{opcode, A, B, rd}` through a registered valid/ready output and takes the ALU result back on a writeback port. A per-register scoreboard stalls RAW/WAW hazards.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 supported.
- `NREG`, 32, architectural register count; x0 hardwired to zero.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: instruction word present.
- `in_instr` input 32: RV32I instruction.
- `in_ready` output 1: stage accepts `in_instr` this cycle.
- `out_valid` output 1: issued micro-op valid.
- `out_ready` input 1: ALU side consumes the micro-op.
- `out_opcode` output 3: ALU opcode.
- `out_a` output 32: operand A (rs1 value).
- `out_b` output 32: operand B (rs2 value, or the immediate).
- `out_rd` output 5: destination register.
- `wb_valid` input 1: writeback strobe.
- `wb_rd` input 5: writeback register.
- `wb_data` input 32: writeback value (ALU result).
- `illegal_instr` output 1: one-cycle pulse when an instruction is dropped.

## Operation
**Decode:** major opcode 0110011 (OP) or 0010011 (OP-IMM). The funct3 to ALU opcode mapping is:
- 000: ADD → 000. For OP with funct7 = 0100000 this is SUB → 001. ADDI is always 000.
- 001: SLL/SLLI → 100.
- 011: SLTU/SLTIU → 111.
- 100: XOR → 110.
- 101: SRL/SRLI → 101. Requires funct7 = 0000000.
- 110: OR → 010.
- 111: AND → 011.

**Illegal instructions:** the following are not issued and pulse `illegal_instr`:
- funct3 010 (SLT/SLTI).
- SRA/SRAI.
- Any other funct7 on OP.
- Any other major opcode.

**Operand B:**
- OP: rs2 value. For shifts it is masked to `{27'b0, rs2[4:0]}`.
- OP-IMM: imm[11:0] sign-extended. SLTIU compares against the sign-extended immediate as unsigned.
- Shift-immediate: `{27'b0, instr[24:20]}`.

**Register file:**
- Reads are combinational.
- x0 reads 0; writes to x0 are ignored.
- On writeback, `wb_data` is written to `wb_rd` when `wb_valid` is high and `wb_rd != 0`.

**Bypass:** when `wb_valid` is high and `wb_rd == rs`, in the same cycle as the read, operand = `wb_data` (rs ≠ 0).

**Scoreboard:** one pending bit per register.
- Set on issue for rd ≠ 0.
- Cleared on writeback.
- Effective pending = pending & ~(writeback-clear this cycle).
- hazard = (rs1 pending) | (rs2 pending, OP only) | (rd pending).
- Same-cycle issue to rd and writeback to the same rd: set wins.

**Handshake:**
- `in_ready` = ~reset & (~out_valid | out_ready) & ~(legal & hazard).
- Accept = `in_valid & in_ready`.
- A legal accept loads the output register and sets `out_valid`.
- An illegal accept drops the instruction. If no issue happens that cycle, `out_valid` is cleared when `out_ready`.

**Writeback:** writeback of a non-pending register still writes the register file.

## Timing
- Issue latency: 1 cycle. Accepted at edge N, the micro-op is on the `out_*` ports after edge N.
- Throughput: 1 instruction/cycle when there are no hazards and `out_ready` is high.
- Output hold: `out_*` stays stable while `out_valid & ~out_ready`.
- Writeback visibility:
  - Same cycle via bypass.
  - Via the register file from the following cycle.
- `illegal_instr` is registered: it asserts the cycle after the accepting edge, for exactly 1 cycle.
- Reset (any cycle, including mid-stall):
  - Outputs: `out_valid` = 0, `out_opcode`/`out_a`/`out_b`/`out_rd` = 0, `illegal_instr` = 0.
  - `in_ready` = 0 during reset.
  - All 31 registers cleared to 0; all pending bits cleared.
  - The in-flight micro-op is discarded.

## Structure
- Shared package `riscv_pkg` holds:
  - ALU opcode localparams (ALU_ADD = 3'b000 … ALU_SLTU = 3'b111).
  - Major opcodes OPC_OP = 7'b0110011 and OPC_OP_IMM = 7'b0010011.
  - funct3/funct7 constants.
- Sub-module `reg_file`:
  - 32x32, 2 combinational read ports, 1 synchronous write port.
  - x0 zero; synchronous reset clear.
- Decode, bypass, scoreboard and output register stay in `decode_issue_stage`.

## Test plan
- **Reset and ADDI:** reset, then ADDI x1,x0,5 with `out_ready` = 1 → next cycle `out_valid` = 1, opcode 000, a = 0, b = 5, rd = 1; `in_ready` then drops for any instruction reading x1 until `wb_valid` with rd = 1, data 5.
- **RAW stall then bypass:** ADD x2,x1,x1 issued while x1 is pending → `in_ready` = 0. Apply wb x1 = 5 in the same cycle → accepted that cycle, next cycle a = 5, b = 5, opcode 000.
- **Register shift masking:** x3 = 0x23, then SLL x4,x5,x3 → opcode 100, b = 3.
- **Immediate decode:**
  - SRLI x6,x5,31 → opcode 101, b = 31.
  - SLTIU x7,x5,-1 → opcode 111, b = 0xFFFFFFFF.
- **Illegal drop:** SRA (funct7 0100000, funct3 101) → `illegal_instr` pulses 1 cycle, `out_valid` stays 0, no pending bit set.
- **Backpressure and mid-stall reset:**
  - Hold `out_ready` = 0 over two back-to-back legal instructions → the first is held stable and `in_ready` = 0.
  - Assert `reset` for 1 cycle → `out_valid` = 0, pending cleared, x1 reads 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants and the ALU opcode encoding used by the issue stage.
package riscv_pkg;
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_SLL  = 3'b100;
  localparam logic [2:0] ALU_SRL  = 3'b101;
  localparam logic [2:0] ALU_XOR  = 3'b110;
  localparam logic [2:0] ALU_SLTU = 3'b111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
  } uop_t;
endpackage

// File: rtl/reg_file.sv
// Architectural register file: two combinational reads, one synchronous write, x0 reads zero.
module reg_file #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   ra1_i,
  input  logic [AW-1:0]   ra2_i,
  output logic [XLEN-1:0] rd1_o,
  output logic [XLEN-1:0] rd2_o,
  input  logic            we_i,
  input  logic [AW-1:0]   wa_i,
  input  logic [XLEN-1:0] wd_i
);
  logic [XLEN-1:0] mem_q [NREG];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (we_i && wa_i != '0) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  assign rd1_o = (ra1_i == '0) ? '0 : mem_q[ra1_i];
  assign rd2_o = (ra2_i == '0) ? '0 : mem_q[ra2_i];
endmodule

// File: rtl/decode_issue_stage.sv
// Decodes RV32I OP/OP-IMM into ALU micro-ops, reads operands with writeback bypass,
// and blocks RAW/WAW hazards with a per-register pending scoreboard.
module decode_issue_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [31:0]     in_instr,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      out_opcode,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [4:0]      out_rd,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            illegal_instr
);
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rs1, rs2, rd;
  logic       is_op, is_imm, f7_ok;
  logic       legal, is_shift;
  logic [2:0] alu_op;

  assign opc    = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign f3     = in_instr[14:12];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign f7     = in_instr[31:25];
  assign is_op  = (opc == OPC_OP);
  assign is_imm = (opc == OPC_OP_IMM);
  assign f7_ok  = is_imm | (f7 == F7_BASE);

  always_comb begin
    legal    = 1'b0;
    is_shift = 1'b0;
    alu_op   = ALU_ADD;
    if (is_op || is_imm) begin
      unique case (f3)
        F3_ADD: begin
          legal  = f7_ok | (f7 == F7_ALT);
          alu_op = (is_op && f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
        end
        F3_SLL:  begin legal = f7_ok; alu_op = ALU_SLL; is_shift = 1'b1; end
        F3_SLT:  legal = 1'b0;
        F3_SLTU: begin legal = f7_ok; alu_op = ALU_SLTU; end
        F3_XOR:  begin legal = f7_ok; alu_op = ALU_XOR; end
        // SRAI shares funct3 with SRLI, so the immediate form must check funct7 too
        F3_SR:   begin legal = (f7 == F7_BASE); alu_op = ALU_SRL; is_shift = 1'b1; end
        F3_OR:   begin legal = f7_ok; alu_op = ALU_OR; end
        F3_AND:  begin legal = f7_ok; alu_op = ALU_AND; end
        default: legal = 1'b0;
      endcase
    end
  end

  logic [XLEN-1:0] rf_rd1, rf_rd2, rs1_val, rs2_val, b_val;

  reg_file #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .clk   (clk),
    .reset (reset),
    .ra1_i (rs1),
    .ra2_i (rs2),
    .rd1_o (rf_rd1),
    .rd2_o (rf_rd2),
    .we_i  (wb_valid),
    .wa_i  (wb_rd),
    .wd_i  (wb_data)
  );

  assign rs1_val = (wb_valid && wb_rd == rs1 && rs1 != '0) ? wb_data : rf_rd1;
  assign rs2_val = (wb_valid && wb_rd == rs2 && rs2 != '0) ? wb_data : rf_rd2;

  always_comb begin
    if (is_op) b_val = is_shift ? {27'b0, rs2_val[4:0]} : rs2_val;
    else       b_val = is_shift ? {27'b0, rs2} : {{20{in_instr[31]}}, in_instr[31:20]};
  end

  logic [NREG-1:0] pend_q, pend_d, pend_eff;
  logic            hazard, accept, issue;
  uop_t            uop_q;
  logic            out_valid_q, illegal_q;

  always_comb begin
    pend_eff = pend_q;
    if (wb_valid) pend_eff[wb_rd] = 1'b0;
  end

  assign hazard   = pend_eff[rs1] | (is_op & pend_eff[rs2]) | pend_eff[rd];
  assign in_ready = ~reset & (~out_valid_q | out_ready) & ~(legal & hazard);
  assign accept   = in_valid & in_ready;
  assign issue    = accept & legal;

  // A new issue re-marks rd even when the same register is being written back.
  always_comb begin
    pend_d = pend_eff;
    if (issue && rd != '0) pend_d[rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q      <= '0;
      uop_q       <= '0;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      illegal_q <= accept & ~legal;
      if (issue) begin
        uop_q       <= '{opcode: alu_op, a: rs1_val, b: b_val, rd: rd};
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid     = out_valid_q;
  assign out_opcode    = uop_q.opcode;
  assign out_a         = uop_q.a;
  assign out_b         = uop_q.b;
  assign out_rd        = uop_q.rd;
  assign illegal_instr = illegal_q;
endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed test of decode, bypass, scoreboard stalls, illegal drop and mid-stall reset.
module tb_decode_issue_stage;
  import riscv_pkg::*;

  logic        clk, reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, out_a, out_b, wb_data;
  logic [2:0]  out_opcode;
  logic [4:0]  out_rd, wb_rd;
  logic        wb_valid, illegal_instr;
  int          total, bad;

  decode_issue_stage dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_instr     (in_instr),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_opcode   (out_opcode),
    .out_a        (out_a),
    .out_b        (out_b),
    .out_rd       (out_rd),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .illegal_instr(illegal_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] s2,
                                         input logic [4:0] s1, input logic [2:0] f3,
                                         input logic [4:0] d);
    return {f7, s2, s1, f3, d, OPC_OP};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] s1,
                                         input logic [2:0] f3, input logic [4:0] d);
    return {imm, s1, f3, d, OPC_OP_IMM};
  endfunction

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    wb_valid = 1'b1; wb_rd = r; wb_data = d;
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;

    tick;
    chk("rst_in_ready", 32'(in_ready), 0);
    tick;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_illegal", 32'(illegal_instr), 0);
    chk("rst_opcode", 32'(out_opcode), 0);
    reset = 1'b0; #1;
    chk("idle_in_ready", 32'(in_ready), 1);

    // ADDI x1,x0,5
    in_valid = 1'b1; in_instr = i_type(12'd5, 5'd0, F3_ADD, 5'd1);
    tick;
    chk("addi_valid", 32'(out_valid), 1);
    chk("addi_op", 32'(out_opcode), 32'(ALU_ADD));
    chk("addi_a", out_a, 0);
    chk("addi_b", out_b, 5);
    chk("addi_rd", 32'(out_rd), 1);

    // ADD x2,x1,x1 stalls on pending x1, then goes with the bypassed writeback
    in_instr = r_type(F7_BASE, 5'd1, 5'd1, F3_ADD, 5'd2); #1;
    chk("raw_stall", 32'(in_ready), 0);
    tick;
    chk("raw_drain_valid", 32'(out_valid), 0);
    chk("raw_still_stall", 32'(in_ready), 0);
    wb(5'd1, 32'd5); #1;
    chk("raw_wb_ready", 32'(in_ready), 1);
    tick;
    wb_valid = 1'b0; in_valid = 1'b0;
    chk("add_valid", 32'(out_valid), 1);
    chk("add_op", 32'(out_opcode), 32'(ALU_ADD));
    chk("add_a", out_a, 5);
    chk("add_b", out_b, 5);
    chk("add_rd", 32'(out_rd), 2);

    // seed registers through writeback (non-pending write)
    wb(5'd3, 32'h23); tick;
    wb(5'd5, 32'h8000_0001); tick;
    // SLL x4,x5,x3 while x2 is retired in the same cycle
    wb(5'd2, 32'd10);
    in_valid = 1'b1; in_instr = r_type(F7_BASE, 5'd3, 5'd5, F3_SLL, 5'd4);
    tick;
    wb_valid = 1'b0;
    chk("sll_op", 32'(out_opcode), 32'(ALU_SLL));
    chk("sll_a", out_a, 32'h8000_0001);
    chk("sll_b", out_b, 3);
    chk("sll_rd", 32'(out_rd), 4);

    // SRLI x6,x5,31
    in_instr = i_type(12'h01F, 5'd5, F3_SR, 5'd6);
    tick;
    chk("srli_op", 32'(out_opcode), 32'(ALU_SRL));
    chk("srli_b", out_b, 31);

    // SLTIU x7,x5,-1
    in_instr = i_type(12'hFFF, 5'd5, F3_SLTU, 5'd7);
    tick;
    chk("sltiu_op", 32'(out_opcode), 32'(ALU_SLTU));
    chk("sltiu_b", out_b, 32'hFFFF_FFFF);
    chk("sltiu_rd", 32'(out_rd), 7);

    // WAW: x4 still pending
    in_instr = i_type(12'd1, 5'd0, F3_ADD, 5'd4); #1;
    chk("waw_stall", 32'(in_ready), 0);

    // SUB x8,x3,x1
    in_instr = r_type(F7_ALT, 5'd1, 5'd3, F3_ADD, 5'd8);
    tick;
    chk("sub_op", 32'(out_opcode), 32'(ALU_SUB));
    chk("sub_a", out_a, 32'h23);
    chk("sub_b", out_b, 5);

    // SRA x9,x3,x1 is dropped
    in_instr = r_type(F7_ALT, 5'd1, 5'd3, F3_SR, 5'd9);
    tick;
    in_valid = 1'b0;
    chk("sra_illegal", 32'(illegal_instr), 1);
    chk("sra_no_issue", 32'(out_valid), 0);
    tick;
    chk("illegal_pulse_end", 32'(illegal_instr), 0);

    // SLT x9,x3,x1 is dropped
    in_valid = 1'b1; in_instr = r_type(F7_BASE, 5'd1, 5'd3, F3_SLT, 5'd9);
    tick;
    in_valid = 1'b0;
    chk("slt_illegal", 32'(illegal_instr), 1);

    // ADDI x10,x9,1: dropped SRA/SLT left x9 free
    in_valid = 1'b1; in_instr = i_type(12'd1, 5'd9, F3_ADD, 5'd10); #1;
    chk("nopend_ready", 32'(in_ready), 1);
    tick;
    in_valid = 1'b0;
    chk("addi10_rd", 32'(out_rd), 10);
    chk("addi10_b", out_b, 1);
    tick;

    // backpressure: ADDI x11,x0,7 held while ADDI x12 waits
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = i_type(12'd7, 5'd0, F3_ADD, 5'd11);
    tick;
    chk("bp_valid", 32'(out_valid), 1);
    chk("bp_rd", 32'(out_rd), 11);
    in_instr = i_type(12'd9, 5'd0, F3_ADD, 5'd12); #1;
    chk("bp_in_ready", 32'(in_ready), 0);
    tick;
    chk("bp_hold_valid", 32'(out_valid), 1);
    chk("bp_hold_b", out_b, 7);
    chk("bp_hold_rd", 32'(out_rd), 11);

    // reset mid-stall
    reset = 1'b1; #1;
    chk("rst2_in_ready", 32'(in_ready), 0);
    tick;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("rst2_out_valid", 32'(out_valid), 0);
    chk("rst2_out_b", out_b, 0);
    chk("rst2_out_rd", 32'(out_rd), 0);

    // ADD x13,x4,x1: x4 no longer pending, x1 cleared
    in_valid = 1'b1; in_instr = r_type(F7_BASE, 5'd1, 5'd4, F3_ADD, 5'd13); #1;
    chk("rst2_pend_clear", 32'(in_ready), 1);
    tick;
    in_valid = 1'b0;
    chk("rst2_valid", 32'(out_valid), 1);
    chk("rst2_x1_zero", out_b, 0);
    chk("rst2_rd", 32'(out_rd), 13);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
